// File: rtl/bus_arbiter_4ch.sv
// Round-robin 4:1 arbiter/sequencer: grants one requester, registers its word, holds it under VALID/ACK.
// Latency REQ->VALID 1 cycle; word is held until ACK (DONE pulse) or TIMEOUT expiry (ERR pulse).
// Optional BUS_ARBITER_FAST_REARB_EN: re-arbitrate on the ACK cycle for back-to-back words.
module bus_arbiter_4ch #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       REQ,
    input  logic [WIDTH-1:0] IN0,
    input  logic [WIDTH-1:0] IN1,
    input  logic [WIDTH-1:0] IN2,
    input  logic [WIDTH-1:0] IN3,
    input  logic             ACK,
    output logic             VALID,
    output logic [WIDTH-1:0] OUT,
    output logic [1:0]       SEL,
    output logic [3:0]       GNT,
    output logic [3:0]       DONE,
    output logic             ERR
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             valid, valid_nxt;
    logic [WIDTH-1:0] dat, dat_nxt;
    logic [1:0]       sel, sel_nxt;
    logic [3:0]       gnt, gnt_nxt;
    logic [3:0]       done, done_nxt;
    logic             err, err_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;

    logic [3:0]       arb_req;
    logic [1:0]       arb_ptr;
    logic [1:0]       arb_idx;
    logic [1:0]       cand;
    logic             arb_hit;
    logic [WIDTH-1:0] arb_dat;
    logic             load;
    logic             retire;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            valid <= 1'b0;
            dat   <= '0;
            sel   <= '0;
            gnt   <= '0;
            done  <= '0;
            err   <= 1'b0;
            ptr   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            valid <= valid_nxt;
            dat   <= dat_nxt;
            sel   <= sel_nxt;
            gnt   <= gnt_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // In BUSY the arbiter only matters for fast re-arbitration: the current owner is masked
    // and the scan starts just after it, matching the pointer update on completion.
    always_comb begin
        arb_req = REQ;
        arb_ptr = ptr;
        if (state == BUSY) begin
            arb_req = REQ & ~gnt;
            arb_ptr = sel + 2'd1;
        end
        arb_hit = 1'b0;
        arb_idx = '0;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = arb_ptr + 2'(k);
            if (arb_req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
        case (arb_idx)
            2'd0:    arb_dat = IN0;
            2'd1:    arb_dat = IN1;
            2'd2:    arb_dat = IN2;
            default: arb_dat = IN3;
        endcase
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = valid;
        dat_nxt   = dat;
        sel_nxt   = sel;
        gnt_nxt   = gnt;
        done_nxt  = '0;
        err_nxt   = 1'b0;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        load      = 1'b0;
        retire    = 1'b0;

        case (state)
            IDLE: begin
                load = arb_hit;
            end
            BUSY: begin
                // ACK takes priority over a timeout expiring in the same cycle.
                if (ACK) begin
                    done_nxt = gnt;
                    retire   = 1'b1;
`ifdef BUS_ARBITER_FAST_REARB_EN
                    load     = arb_hit;
`endif
                end else if (TO_EN && (cnt == CNT_LAST)) begin
                    err_nxt = 1'b1;
                    retire  = 1'b1;
                end else if (TO_EN) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (retire) begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
            gnt_nxt   = '0;
            ptr_nxt   = sel + 2'd1;
        end
        if (load) begin
            state_nxt = BUSY;
            valid_nxt = 1'b1;
            sel_nxt   = arb_idx;
            gnt_nxt   = 4'(4'b0001 << arb_idx);
            dat_nxt   = arb_dat;
            cnt_nxt   = '0;
        end
    end

    assign VALID = valid;
    assign OUT   = dat;
    assign SEL   = sel;
    assign GNT   = gnt;
    assign DONE  = done;
    assign ERR   = err;

endmodule
